// File: rtl/booth_mac_accum.sv
// Saturating multiply-accumulate stage fed by the Booth multiplier.
// Sums N_TERMS signed products (or fewer on flush) and presents the result over valid/ready.
module booth_mac_accum #(
  parameter int PROD_W  = 18,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [PROD_W-1:0] i_prod_in,
  input  logic                     i_prod_valid,
  output logic                     o_prod_ready,
  input  logic                     i_flush,
  input  logic                     i_clear,
  output logic signed [ACC_W-1:0]  o_acc_out,
  output logic                     o_acc_valid,
  input  logic                     i_acc_ready,
  output logic                     o_overflow,
  output logic [CNT_W-1:0]         o_term_count
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("booth_mac_accum: ACC_W must be >= PROD_W");
  end
  if (N_TERMS < 1 || N_TERMS > (2**CNT_W) - 1) begin : g_bad_terms
    $error("booth_mac_accum: N_TERMS out of range for CNT_W");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]        LP_LAST    = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] LP_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LP_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_pop;
  logic signed [ACC_W:0]     w_prod_ext;
  logic signed [ACC_W:0]     w_acc_ext;
  logic signed [ACC_W:0]     w_sum_wide;
  logic                      w_sum_ovf;
  logic signed [ACC_W-1:0]   w_sum_sat;

  assign w_accept = i_prod_valid && o_prod_ready;
  assign w_last   = (r_cnt == LP_LAST);
  assign w_pop    = (r_state == ST_HOLD) && i_acc_ready;

  // One guard bit: the two top bits disagree exactly when the ACC_W-bit sum overflowed.
  assign w_prod_ext = {{(ACC_W + 1 - PROD_W){i_prod_in[PROD_W-1]}}, i_prod_in};
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum_wide = w_acc_ext + w_prod_ext;
  assign w_sum_ovf  = w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1];

  always_comb begin
    w_sum_sat = w_sum_wide[ACC_W-1:0];
    if (w_sum_ovf) begin
      w_sum_sat = w_sum_wide[ACC_W] ? LP_ACC_MIN : LP_ACC_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && (w_last || i_flush)) begin
            w_state_nxt = ST_HOLD;
          end else if (i_flush && (r_cnt != '0)) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_acc_ready) begin
            w_state_nxt = ST_ACCUM;
          end
        end
        default: w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    o_prod_ready = (r_state == ST_ACCUM) && !i_clear;
    o_acc_valid  = (r_state == ST_HOLD);
    o_acc_out    = r_acc;
    o_overflow   = r_ovf;
    o_term_count = r_cnt;
  end

  // Clear and pop both start a fresh result; accept cannot coincide with either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear || w_pop) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum_sat;
      r_ovf <= r_ovf | w_sum_ovf;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum: three instances cover the short-result,
// narrow-accumulator saturation and long-result/flush configurations.
module tb_booth_mac_accum;

  logic clk;
  logic rst;

  // Instance A: N_TERMS=4, default widths
  logic signed [17:0] a_prod;
  logic               a_valid, a_ready, a_flush, a_clear, a_vld, a_acc_ready, a_ovf;
  logic signed [23:0] a_acc;
  logic [4:0]         a_cnt;

  // Instance B: ACC_W=20, PROD_W=18, N_TERMS=8
  logic signed [17:0] b_prod;
  logic               b_valid, b_ready, b_flush, b_clear, b_vld, b_acc_ready, b_ovf;
  logic signed [19:0] b_acc;
  logic [4:0]         b_cnt;

  // Instance C: N_TERMS=16
  logic signed [17:0] c_prod;
  logic               c_valid, c_ready, c_flush, c_clear, c_vld, c_acc_ready, c_ovf;
  logic signed [23:0] c_acc;
  logic [4:0]         c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  booth_mac_accum #(.PROD_W(18), .ACC_W(24), .N_TERMS(4), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .i_prod_in(a_prod), .i_prod_valid(a_valid),
    .o_prod_ready(a_ready), .i_flush(a_flush), .i_clear(a_clear),
    .o_acc_out(a_acc), .o_acc_valid(a_vld), .i_acc_ready(a_acc_ready),
    .o_overflow(a_ovf), .o_term_count(a_cnt)
  );

  booth_mac_accum #(.PROD_W(18), .ACC_W(20), .N_TERMS(8), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .i_prod_in(b_prod), .i_prod_valid(b_valid),
    .o_prod_ready(b_ready), .i_flush(b_flush), .i_clear(b_clear),
    .o_acc_out(b_acc), .o_acc_valid(b_vld), .i_acc_ready(b_acc_ready),
    .o_overflow(b_ovf), .o_term_count(b_cnt)
  );

  booth_mac_accum #(.PROD_W(18), .ACC_W(24), .N_TERMS(16), .CNT_W(5)) dut_c (
    .clk(clk), .rst(rst), .i_prod_in(c_prod), .i_prod_valid(c_valid),
    .o_prod_ready(c_ready), .i_flush(c_flush), .i_clear(c_clear),
    .o_acc_out(c_acc), .o_acc_valid(c_vld), .i_acc_ready(c_acc_ready),
    .o_overflow(c_ovf), .o_term_count(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int a_terms[4] = '{3, -5, 7, 100};
  int a_runs[4]  = '{3, -2, 5, 105};

  initial begin
    rst = 1'b1;
    {a_valid, a_flush, a_clear, a_acc_ready} = '0;
    {b_valid, b_flush, b_clear, b_acc_ready} = '0;
    {c_valid, c_flush, c_clear, c_acc_ready} = '0;
    a_prod = '0; b_prod = '0; c_prod = '0;
    #23;
    rst = 1'b0;
    step();

    chk("rst_acc", a_acc, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_prod_ready", a_ready, 1);

    // back-to-back 3,-5,7,100
    a_acc_ready = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_prod = 18'(a_terms[i]);
      step();
      chk("b2b_run", a_acc, a_runs[i]);
      chk("b2b_cnt", a_cnt, i + 1);
    end
    a_valid = 1'b0;
    chk("b2b_vld", a_vld, 1);
    chk("b2b_ovf", a_ovf, 0);
    chk("b2b_hold_ready", a_ready, 0);
    step();
    chk("b2b_pop_vld", a_vld, 0);
    chk("b2b_pop_acc", a_acc, 0);
    chk("b2b_pop_cnt", a_cnt, 0);

    // backpressure: result held 5 cycles while upstream keeps offering
    a_acc_ready = 1'b0;
    a_valid = 1'b1;
    a_prod = 18'sd10;
    for (int i = 0; i < 4; i++) step();
    a_prod = 18'sd7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_prod_ready", a_ready, 0);
      chk("bp_acc_held", a_acc, 40);
      chk("bp_vld", a_vld, 1);
    end
    a_acc_ready = 1'b1;
    step();
    chk("bp_pop_vld", a_vld, 0);
    chk("bp_pop_acc", a_acc, 0);
    step();
    chk("bp_next_from_zero", a_acc, 7);
    chk("bp_next_cnt", a_cnt, 1);

    // clear mid-result
    a_clear = 1'b1;
    a_prod = 18'sd9;
    #1;
    chk("clr_prod_ready", a_ready, 0);
    step();
    a_clear = 1'b0;
    a_prod = 18'sd20;
    step();
    a_prod = 18'sd30;
    step();
    chk("clr_pre_acc", a_acc, 50);
    chk("clr_pre_cnt", a_cnt, 2);
    a_clear = 1'b1;
    a_prod = 18'sd9;
    #1;
    chk("clr_prod_ready2", a_ready, 0);
    step();
    chk("clr_acc", a_acc, 0);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_vld", a_vld, 0);
    a_clear = 1'b0;
    a_prod = 18'sd1;
    for (int i = 0; i < 4; i++) step();
    chk("clr_after_acc", a_acc, 4);
    chk("clr_after_vld", a_vld, 1);
    chk("clr_after_cnt", a_cnt, 4);
    a_valid = 1'b0;
    step();
    chk("clr_after_pop", a_vld, 0);

    // flush together with an accept includes that product
    a_valid = 1'b1;
    a_prod = 18'sd5;
    step();
    a_flush = 1'b1;
    a_prod = 18'sd6;
    step();
    a_flush = 1'b0;
    a_valid = 1'b0;
    chk("flacc_acc", a_acc, 11);
    chk("flacc_cnt", a_cnt, 2);
    chk("flacc_vld", a_vld, 1);
    step();

    // positive saturation on the 20-bit accumulator
    b_acc_ready = 1'b1;
    b_valid = 1'b1;
    b_prod = 18'sd131071;
    for (int i = 0; i < 4; i++) step();
    chk("psat_pre_acc", b_acc, 524284);
    chk("psat_pre_ovf", b_ovf, 0);
    step();
    chk("psat_acc", b_acc, 524287);
    chk("psat_ovf", b_ovf, 1);
    b_valid = 1'b0;
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    chk("psat_flush_vld", b_vld, 1);
    chk("psat_flush_cnt", b_cnt, 5);
    step();
    chk("psat_pop_ovf", b_ovf, 0);

    // negative saturation: 8 x -131072
    b_acc_ready = 1'b0;
    b_valid = 1'b1;
    b_prod = -18'sd131072;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) begin
        chk("nsat4_acc", b_acc, -524288);
        chk("nsat4_ovf", b_ovf, 0);
      end else if (i == 5) begin
        chk("nsat5_acc", b_acc, -524288);
        chk("nsat5_ovf", b_ovf, 1);
      end
    end
    chk("nsat_final_acc", b_acc, -524288);
    chk("nsat_final_ovf", b_ovf, 1);
    chk("nsat_final_vld", b_vld, 1);

    // flush with nothing accumulated is ignored
    c_flush = 1'b1;
    step();
    c_flush = 1'b0;
    chk("fl0_vld", c_vld, 0);
    chk("fl0_ready", c_ready, 1);
    c_valid = 1'b1;
    c_prod = 18'sd10; step();
    c_prod = 18'sd20; step();
    c_prod = 18'sd30; step();
    c_valid = 1'b0;
    c_flush = 1'b1;
    step();
    chk("fl_acc", c_acc, 60);
    chk("fl_cnt", c_cnt, 3);
    chk("fl_vld", c_vld, 1);
    step();
    chk("fl_hold_vld", c_vld, 1);
    chk("fl_hold_acc", c_acc, 60);
    c_flush = 1'b0;
    c_acc_ready = 1'b1;
    step();
    chk("fl_pop_vld", c_vld, 0);

    // async reset while instance B holds a saturated result
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vld", b_vld, 0);
    chk("arst_acc", b_acc, 0);
    chk("arst_ovf", b_ovf, 0);
    chk("arst_cnt", b_cnt, 0);
    chk("arst_ready", b_ready, 1);
    b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_after_vld", b_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
